// File: rtl/vib_pkg.sv
// rtl/vib_pkg.sv - shared constants and channel state type for the vibration channel feeder
package vib_pkg;
    localparam int DATAWIDTH = 16;
    localparam int NCH = 4;
    localparam logic [15:0] BASE_CONST_DEF = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/vib_chan_fsm.sv
// rtl/vib_chan_fsm.sv - one channel: holding register, pulse/gap FSM and baseline
// Running-average baseline exists only when VIB_BASELINE_EN is defined.
module vib_chan_fsm
    import vib_pkg::*;
#(
    parameter int DW = DATAWIDTH,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN = 3,
    parameter int AVG_SHIFT = 4,
    parameter logic [DW-1:0] BASE_CONST = DW'(BASE_CONST_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept,
    input  logic [DW-1:0] sample,
    output logic          pend,
    output logic [DW-1:0] dat,
    output logic          enable,
    output logic [DW-1:0] base_line
);
    localparam int CW = 8;

    if (PULSE_LEN < 3 || GAP_LEN < 3 || PULSE_LEN > 255 || GAP_LEN > 255 || AVG_SHIFT > DW)
    begin : g_bad_param
        $error("vib_chan_fsm: parameter out of range");
    end

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DW-1:0] hold;
    logic          load;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    state_nx = PULSE;
                    cnt_nx   = '0;
                    load     = 1'b1;
                end
            end
            PULSE: begin
                if (cnt == CW'(PULSE_LEN - 1)) begin
                    state_nx = GAP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            GAP: begin
                if (cnt == CW'(GAP_LEN - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign enable = (state == PULSE);

    // accept is gated by ~pend upstream, so it never collides with the load clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 1'b0;
            hold <= '0;
            dat  <= '0;
        end else begin
            if (accept) begin
                hold <= sample;
                pend <= 1'b1;
            end else if (load) begin
                pend <= 1'b0;
            end
            if (load) begin
                dat <= hold;
            end
        end
    end

`ifdef VIB_BASELINE_EN
    logic          init;
    logic [DW-1:0] base;
    logic signed [DW:0] diff;

    assign diff = $signed({1'b0, hold}) - $signed({1'b0, base});

    // floor-shifted step never overshoots the sample, so DW bits suffice
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init <= 1'b0;
            base <= '0;
        end else if (load) begin
            init <= 1'b1;
            base <= init ? base + DW'(diff >>> AVG_SHIFT) : hold;
        end
    end

    assign base_line = base;
`else
    assign base_line = BASE_CONST;
`endif
endmodule

// File: rtl/vib_chan_feeder.sv
// rtl/vib_chan_feeder.sv - demultiplexes a tagged ADC stream into four pulsed channels
// Optional averaged baselines are enabled by defining VIB_BASELINE_EN.
module vib_chan_feeder
    import vib_pkg::*;
#(
    parameter int DATAWIDTH = vib_pkg::DATAWIDTH,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN = 3,
    parameter int AVG_SHIFT = 4,
    parameter logic [DATAWIDTH-1:0] BASE_CONST = DATAWIDTH'(BASE_CONST_DEF)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 adc_valid,
    input  logic [1:0]           adc_ch,
    input  logic [DATAWIDTH-1:0] adc_dat,
    output logic                 adc_ready,
    output logic [DATAWIDTH-1:0] dat0,
    output logic [DATAWIDTH-1:0] dat1,
    output logic [DATAWIDTH-1:0] dat2,
    output logic [DATAWIDTH-1:0] dat3,
    output logic                 dat0_enable,
    output logic                 dat1_enable,
    output logic                 dat2_enable,
    output logic                 dat3_enable,
    output logic [DATAWIDTH-1:0] dat0_base_line,
    output logic [DATAWIDTH-1:0] dat1_base_line,
    output logic [DATAWIDTH-1:0] dat2_base_line,
    output logic [DATAWIDTH-1:0] dat3_base_line
);
    logic [NCH-1:0]       pend_a;
    logic [NCH-1:0]       en_a;
    logic [DATAWIDTH-1:0] dat_a  [NCH];
    logic [DATAWIDTH-1:0] base_a [NCH];

    assign adc_ready = ~pend_a[adc_ch];

    for (genvar n = 0; n < NCH; n++) begin : g_chan
        vib_chan_fsm #(
            .DW        (DATAWIDTH),
            .PULSE_LEN (PULSE_LEN),
            .GAP_LEN   (GAP_LEN),
            .AVG_SHIFT (AVG_SHIFT),
            .BASE_CONST(BASE_CONST)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .accept   (adc_valid && adc_ready && (adc_ch == 2'(n))),
            .sample   (adc_dat),
            .pend     (pend_a[n]),
            .dat      (dat_a[n]),
            .enable   (en_a[n]),
            .base_line(base_a[n])
        );
    end

    assign dat0 = dat_a[0];
    assign dat1 = dat_a[1];
    assign dat2 = dat_a[2];
    assign dat3 = dat_a[3];
    assign dat0_enable = en_a[0];
    assign dat1_enable = en_a[1];
    assign dat2_enable = en_a[2];
    assign dat3_enable = en_a[3];
    assign dat0_base_line = base_a[0];
    assign dat1_base_line = base_a[1];
    assign dat2_base_line = base_a[2];
    assign dat3_base_line = base_a[3];
endmodule

// File: tb/tb_vib_chan_feeder.sv
// tb/tb_vib_chan_feeder.sv - randomized self-checking bench for vib_chan_feeder
module tb_vib_chan_feeder;
    localparam int PULSE = 4;
    localparam int GAP = 3;
    localparam int SHIFT = 4;
`ifdef VIB_BASELINE_EN
    localparam bit BASE_EN = 1'b1;
`else
    localparam bit BASE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        adc_valid = 1'b0;
    logic [1:0]  adc_ch = 2'd0;
    logic [15:0] adc_dat = 16'd0;
    logic        adc_ready;
    logic [15:0] dat0, dat1, dat2, dat3;
    logic        dat0_enable, dat1_enable, dat2_enable, dat3_enable;
    logic [15:0] dat0_base_line, dat1_base_line, dat2_base_line, dat3_base_line;

    vib_chan_feeder dut (
        .clk(clk), .rst(rst),
        .adc_valid(adc_valid), .adc_ch(adc_ch), .adc_dat(adc_dat), .adc_ready(adc_ready),
        .dat0(dat0), .dat1(dat1), .dat2(dat2), .dat3(dat3),
        .dat0_enable(dat0_enable), .dat1_enable(dat1_enable),
        .dat2_enable(dat2_enable), .dat3_enable(dat3_enable),
        .dat0_base_line(dat0_base_line), .dat1_base_line(dat1_base_line),
        .dat2_base_line(dat2_base_line), .dat3_base_line(dat3_base_line)
    );

    always #5 clk = ~clk;

    logic [15:0] dat_o [4];
    logic        en_o  [4];
    logic [15:0] base_o[4];
    assign dat_o[0] = dat0;  assign dat_o[1] = dat1;  assign dat_o[2] = dat2;  assign dat_o[3] = dat3;
    assign en_o[0] = dat0_enable;  assign en_o[1] = dat1_enable;
    assign en_o[2] = dat2_enable;  assign en_o[3] = dat3_enable;
    assign base_o[0] = dat0_base_line;  assign base_o[1] = dat1_base_line;
    assign base_o[2] = dat2_base_line;  assign base_o[3] = dat3_base_line;

    int n_checks = 0;
    int n_err = 0;

    // Reference model: each channel is described by the cycle its sample was
    // accepted, the first cycle it is free again, and the cycle its pulse began.
    int cyc;
    int m_pend[4], m_val[4], m_acc[4], m_free[4], m_en[4], m_dat[4], m_base[4], m_init[4];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int n = 0; n < 4; n++) begin
            m_pend[n] = 0; m_val[n] = 0; m_acc[n] = 0; m_free[n] = 0;
            m_en[n] = -1000; m_dat[n] = 0; m_init[n] = 0;
            m_base[n] = BASE_EN ? 0 : 32'h8000;
        end
    endtask

    task automatic model_tick();
        for (int n = 0; n < 4; n++) begin
            if (m_pend[n] != 0) begin
                int load_cyc;
                load_cyc = (m_acc[n] + 1 > m_free[n]) ? m_acc[n] + 1 : m_free[n];
                if (cyc == load_cyc + 1) begin
                    m_dat[n] = m_val[n];
                    if (BASE_EN) begin
                        if (m_init[n] == 0) m_base[n] = m_val[n];
                        else m_base[n] = m_base[n] + ((m_val[n] - m_base[n]) >>> SHIFT);
                        m_init[n] = 1;
                    end
                    m_en[n]   = cyc;
                    m_free[n] = cyc + PULSE + GAP;
                    m_pend[n] = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int n = 0; n < 4; n++) begin
            check_val($sformatf("enable%0d", n), 32'(en_o[n]),
                      32'((cyc >= m_en[n]) && (cyc < m_en[n] + PULSE)));
            check_val($sformatf("dat%0d", n), 32'(dat_o[n]), 32'(m_dat[n]));
            check_val($sformatf("base%0d", n), 32'(base_o[n]), 32'(m_base[n]));
        end
        check_val("adc_ready", 32'(adc_ready), 32'(m_pend[adc_ch] == 0));
    endtask

    // one cycle: drive at the falling edge, check, then advance model past the next edge
    task automatic step(input logic v, input logic [1:0] ch, input logic [15:0] d);
        adc_valid = v; adc_ch = ch; adc_dat = d;
        #1;
        check_outputs();
        if (v && m_pend[ch] == 0) begin
            m_pend[ch] = 1; m_val[ch] = 32'(d); m_acc[ch] = cyc;
        end
        @(negedge clk);
        cyc++;
        model_tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 16'd0);
    endtask

    task automatic offer(input logic [1:0] ch, input logic [15:0] d);
        int k;
        k = 0;
        while (m_pend[ch] != 0 && k < 50) begin
            step(1'b1, ch, d);
            k++;
        end
        check_val("offer_stall_bound", 32'(k < 50), 32'd1);
        step(1'b1, ch, d);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
        @(negedge clk);
        model_reset();

        // single sample on ch1 straight out of reset
        offer(2'd1, 16'h1234);
        idle(1);
        check_val("ch1_first_en", 32'(en_o[1]), 32'd1);
        check_val("ch1_first_dat", 32'(dat_o[1]), 32'h1234);
        idle(6);

        // back-to-back ch0 samples
        offer(2'd0, 16'h8000);
        offer(2'd0, 16'h8100);
        idle(12);
        check_val("ch0_b2b_dat", 32'(dat_o[0]), 32'h8100);
        check_val("ch0_b2b_base", 32'(base_o[0]), BASE_EN ? 32'h8010 : 32'h8000);
        idle(10);

        // three consecutive ch2 samples: one pends, one stalls
        offer(2'd2, 16'h1111);
        offer(2'd2, 16'h2222);
        offer(2'd2, 16'h3333);
        idle(20);
        check_val("ch2_last_dat", 32'(dat_o[2]), 32'h3333);

        // all channels interleaved
        for (int n = 0; n < 4; n++) step(1'b1, 2'(n), 16'($urandom));
        idle(20);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom));
        idle(20);

        // reset in the middle of a ch3 pulse
        offer(2'd3, 16'hBEEF);
        idle(2);
        check_val("ch3_pre_rst_en", 32'(en_o[3]), 32'd1);
        rst = 1'b0;
        #1;
        check_val("ch3_rst_en", 32'(en_o[3]), 32'd0);
        check_val("ch3_rst_dat", 32'(dat_o[3]), 32'd0);
        check_val("rst_ready", 32'(adc_ready), 32'd1);
        check_val("ch3_rst_base", 32'(base_o[3]), BASE_EN ? 32'd0 : 32'h8000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        offer(2'd3, 16'h0100);
        idle(3);
        check_val("ch3_post_rst_base", 32'(base_o[3]), BASE_EN ? 32'h0100 : 32'h8000);

        offer(2'd0, 16'h0000);
        idle(10);
        check_val("ch0_zero_base", 32'(base_o[0]), BASE_EN ? 32'h0000 : 32'h8000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/vib_chan_feeder.md
VIB_CHAN_FEEDER -- requirements
Module: vib_chan_feeder

Interface
REQ-001 Parameter DATAWIDTH, default 16: sample and baseline width.
REQ-002 Parameter PULSE_LEN, default 4: cycles each datN_enable stays high per sample; minimum 3.
REQ-003 Parameter GAP_LEN, default 3: minimum low cycles between enable pulses on one channel; minimum 3.
REQ-004 Parameter AVG_SHIFT, default 4: baseline averaging shift (time constant 2^AVG_SHIFT samples).
REQ-005 Parameter BASE_CONST, default 16'h8000: fixed baseline used when VIB_BASELINE_EN is undefined.
REQ-006 clk  in  1  sole clock; all logic on posedge clk.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 adc_valid  in  1  multiplexed ADC sample present.
REQ-009 adc_ch  in  2  channel tag of the sample, 0..3.
REQ-010 adc_dat  in  16  unsigned sample.
REQ-011 adc_ready  out  1  sample accepted on the cycle where adc_valid and adc_ready are both high.
REQ-012 dat0..dat3  out  16 each  per-channel sample, held stable from the enable rising edge until the next load.
REQ-013 dat0_enable..dat3_enable  out  1 each  per-channel sample strobe, high for PULSE_LEN cycles.
REQ-014 dat0_base_line..dat3_base_line  out  16 each  per-channel baseline.

Function
REQ-015 adc_ready SHALL equal ~pend[adc_ch]; pend[n] is a one-entry holding register per channel.
REQ-016 On accept, the sample SHALL be written to hold[adc_ch] and pend[adc_ch] set on the next edge.
REQ-017 Each channel FSM SHALL have states IDLE, PULSE, GAP. IDLE->PULSE when pend=1: load datN<=hold, clear pend, set datN_enable=1.
REQ-018 PULSE SHALL last exactly PULSE_LEN cycles with enable high, then go to GAP with enable low.
REQ-019 GAP SHALL last exactly GAP_LEN cycles, then go to IDLE. Back-to-back samples SHALL give enable period PULSE_LEN+GAP_LEN+1 cycles.
REQ-020 Latency: enable SHALL rise 2 cycles after the accept edge if the channel is IDLE.
REQ-021 An accept and a pend clear on the same channel in the same cycle cannot occur; adc_ready is low while pend=1.
REQ-022 Baseline update SHALL occur on the IDLE->PULSE load: base <= base + ((s - base) >>> AVG_SHIFT). Use 17-bit signed difference and arithmetic shift; the result SHALL stay within 0..65535.
REQ-023 The first load after reset SHALL set base = s directly. A per-channel init flag SHALL track this.
REQ-024 Channels SHALL be fully independent. Simultaneous activity on all four SHALL produce no interaction.
REQ-025 datN SHALL NOT change while datN_enable is high or during GAP.

Reset
REQ-026 When rst=0: all FSMs SHALL go to IDLE, pend=0, init=0, datN=0, datN_enable=0, adc_ready=1, datN_base_line=0 (BASE_CONST without the macro). This takes effect immediately, including mid-pulse.
REQ-027 After release, the first sample per channel SHALL behave as in REQ-023.

Configuration
REQ-028 With macro VIB_BASELINE_EN defined, baselines SHALL follow REQ-022/023.
REQ-029 Without VIB_BASELINE_EN, all datN_base_line SHALL be constant BASE_CONST, and no averaging logic or init flags SHALL exist.

Structure
REQ-030 Package vib_pkg SHALL hold DATAWIDTH, NCH=4, the FSM state enum {IDLE, PULSE, GAP} and the default BASE_CONST.
REQ-031 Sub-module vib_chan_fsm (pend/hold, FSM, counter, baseline) SHALL be instantiated once per channel. The top SHALL only decode adc_ch and mux adc_ready.

Verification
REQ-032 Reset release, ch1 sample 0x1234 accepted at cycle 0 -> dat1=0x1234, dat1_enable high cycles 2..5, dat1_base_line=0x1234.
REQ-033 Ch0 samples 0x8000 then 0x8100, back-to-back -> second enable rises 8 cycles after the first; base = 0x8000 + (0x100>>>4) = 0x8010.
REQ-034 Three ch2 samples offered on consecutive cycles -> second held in pend, third stalled (adc_ready=0 while adc_ch=2) until pend clears; no sample lost or reordered.
REQ-035 Interleaved ch0..ch3 samples each cycle -> four independent pulses, each data correct, no cross-channel corruption.
REQ-036 rst asserted mid-PULSE on ch3 -> dat3_enable drops in the same cycle; next sample 0x0100 yields base 0x0100.
REQ-037 Build without VIB_BASELINE_EN, ch0 sample 0x0000 -> dat0_base_line stays 0x8000.
